seg7_scan_counter: RTL and testbench
====================================

// Module: seg7_scan_counter
// PURPOSE
//  Parametrised multi-digit event counter with a time-multiplexed 7-segment display driver.
//  Counts enable pulses in per-digit radix 10 or 16 and exposes the packed count.
//  Scans one digit at a time onto a shared full 7-segment bus with a one-hot digit select.
//  Sits between a tick source (the clock generator or a prescaler) and the board display pins.
// PARAMETERS
//  DIGITS    4   number of display digits (1..8); count width = 4*DIGITS
//  HEX       1   1: digit radix 16 (0..F); 0: BCD, radix 10 (0..9)
//  SCAN_DIV  16  clock cycles each digit is held on the bus (>=2)
// PORTS
//  clock      in   1         rising-edge clock
//  reset      in   1         asynchronous, active-high
//  enable     in   1         count one step on this cycle
//  clear      in   1         synchronous clear of the count
//  count      out  4*DIGITS  packed count; digit k = count[4k+3:4k]
//  carry_out  out  1         one-cycle pulse when the full count wraps to zero
//  seg        out  7         segments {g,f,e,d,c,b,a}, active-high, registered
//  digit_sel  out  DIGITS    one-hot digit enable, registered
// BEHAVIOUR
//  Reset (async assert; sync release on clock): count=0, carry_out=0, prescaler=0,
//  scan index=0, digit_sel=1 (bit 0 set), seg=7'h3F (glyph 0).
//  Counter:
//  - clear has priority over enable. A clear cycle gives count=0 and carry_out=0.
//  - enable: digit 0 increments. Digit k+1 increments only when digits 0..k are all at max
//    (9 or F). A digit at max wraps to 0.
//  - Full wrap (all digits at max, enable=1): count becomes 0 and carry_out=1 for exactly that
//    cycle. Otherwise carry_out=0.
//  - count updates on the clock edge after enable is sampled (latency 1).
//  - BCD mode: a digit never holds a value above 9.
//  Scan:
//  - The prescaler counts 0..SCAN_DIV-1 and wraps.
//  - At its terminal value the scan index advances. It goes from DIGITS-1 back to 0.
//  - digit_sel = one-hot(scan index), registered.
//  - seg = decode(digit[scan index]), registered in the same cycle as digit_sel, so
//    digit_sel and seg always change together.
//  - seg reflects a count change one cycle after count changes when that digit is selected.
//  - The scan runs continuously and is independent of enable and clear.
//  Decode table (hex, {g..a}):
//    0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//    8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
//  - Segment e (bit 4) is lit for 0,2,6,8,A,b,C,d,E,F.
//  - In BCD mode, codes above 9 cannot occur; the decoder still uses the table.
//  Reset mid-scan or mid-count: all state returns to reset values immediately,
//  with no partial digit update.
// CONFIGURATION
//  SEG7_BLANK_EN defined: leading-zero blanking.
//  - While digit k is scanned, seg=7'h00 if digit k and every higher digit are 0.
//  - Digit 0 is never blanked (a count of 0 shows a single "0").
//  - digit_sel still scans all digits.
//  - The reset value of seg is unchanged (7'h3F).
//  SEG7_BLANK_EN undefined: every digit is always decoded; no blanking logic is present.
// TESTING
//  1. Reset mid-run at count=0x1234, scan index 2
//     -> count=0, digit_sel=4'b0001, seg=3F, carry_out=0 while reset is held.
//  2. HEX=0, DIGITS=4, 10 enable pulses from 0
//     -> count=16'h0010.
//     Preload to 9999 + 1 enable -> count=0000, carry_out=1 for one cycle.
//  3. HEX=1, DIGITS=4, count=FFFF + 1 enable
//     -> count=0000, carry_out=1; a further enable gives 0001, carry_out=0.
//  4. SCAN_DIV=4, DIGITS=4, free run
//     -> digit_sel cycles 0001,0010,0100,1000,0001, each held exactly 4 clocks;
//        seg equals the table entry for the selected digit.
//  5. enable=1 and clear=1 in the same cycle at count=0x0009
//     -> count=0, carry_out=0.
//  6. SEG7_BLANK_EN, count=0x0042
//     -> seg=00 for digits 3 and 2, seg=66 for digit 1, seg=5B for digit 0.
//     count=0 -> only digit 0 shows 3F.

Source files
------------

// File: rtl/seg7_scan_counter.sv
// Multi-digit radix-10/16 event counter driving a time-multiplexed 7-segment display.
// Latency: count and carry_out 1 cycle after enable; seg/digit_sel registered, seg trails count by 1 cycle.
// Backpressure: none; enable is taken every cycle, the scan free-runs regardless of enable/clear.
// Optional feature: define SEG7_BLANK_EN for leading-zero blanking of the higher digits.
module seg7_scan_counter #(
    parameter int DIGITS   = 4,   // 1..8 display digits
    parameter int HEX      = 1,   // 1: radix 16 per digit, 0: BCD
    parameter int SCAN_DIV = 16   // clocks each digit stays on the bus, >= 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry_out,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int              CW        = 4 * DIGITS;
    localparam int              PW        = $clog2(SCAN_DIV);
    localparam int              IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0]      DIGIT_MAX = (HEX != 0) ? 4'hF : 4'h9;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(DIGITS - 1);

    // Glyph table, segments {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg7_decode(input logic [3:0] value);
        logic [6:0] glyph;
        case (value)
            4'h0:    glyph = 7'h3F;
            4'h1:    glyph = 7'h06;
            4'h2:    glyph = 7'h5B;
            4'h3:    glyph = 7'h4F;
            4'h4:    glyph = 7'h66;
            4'h5:    glyph = 7'h6D;
            4'h6:    glyph = 7'h7D;
            4'h7:    glyph = 7'h07;
            4'h8:    glyph = 7'h7F;
            4'h9:    glyph = 7'h6F;
            4'hA:    glyph = 7'h77;
            4'hB:    glyph = 7'h7C;
            4'hC:    glyph = 7'h39;
            4'hD:    glyph = 7'h5E;
            4'hE:    glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
        return glyph;
    endfunction

    // ------------------------------------------------------------------
    // Counter
    // ------------------------------------------------------------------
    logic [CW-1:0] count_next;
    logic          wrap;

    // Ripple increment: digit k steps only while every lower digit sits at its max.
    always_comb begin
        logic chain;
        chain      = 1'b1;
        count_next = count;
        for (int k = 0; k < DIGITS; k++) begin
            if (chain) begin
                // ">=" also folds any out-of-range BCD code back to zero.
                if (count[4*k +: 4] >= DIGIT_MAX) begin
                    count_next[4*k +: 4] = 4'h0;
                end else begin
                    count_next[4*k +: 4] = count[4*k +: 4] + 4'h1;
                end
            end
            chain = chain && (count[4*k +: 4] == DIGIT_MAX);
        end
        wrap = chain;
    end

    // Count register; clear beats enable, carry_out pulses only on a full wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            carry_out <= 1'b0;
        end else if (clear) begin
            count     <= '0;
            carry_out <= 1'b0;
        end else if (enable) begin
            count     <= count_next;
            carry_out <= wrap;
        end else begin
            carry_out <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [PW-1:0]     prescale;
    logic [IW-1:0]     scan_idx;
    logic [IW-1:0]     idx_next;
    logic [DIGITS-1:0] sel_next;
    logic [3:0]        scan_digit;
    logic              blank;

    // Prescaler free-runs 0..SCAN_DIV-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescale <= '0;
        end else if (prescale == PRE_LAST) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    // Next scan position; seg and digit_sel are both built from it so they move together.
    always_comb begin
        idx_next = scan_idx;
        if (prescale == PRE_LAST) begin
            if (scan_idx == IDX_LAST) begin
                idx_next = '0;
            end else begin
                idx_next = scan_idx + IW'(1);
            end
        end
    end

    // One-hot select and the digit value that will be shown at the next position.
    always_comb begin
        sel_next   = '0;
        scan_digit = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_next == IW'(k)) begin
                sel_next[k] = 1'b1;
                scan_digit  = count[4*k +: 4];
            end
        end
    end

`ifdef SEG7_BLANK_EN
    logic [DIGITS-1:0] upper_zero;

    // upper_zero[k]: digit k and everything above it are zero; digit 0 is never blanked.
    always_comb begin
        logic chain;
        chain      = 1'b1;
        upper_zero = '0;
        blank      = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            chain         = chain && (count[4*k +: 4] == 4'h0);
            upper_zero[k] = chain;
        end
        for (int k = 1; k < DIGITS; k++) begin
            if (idx_next == IW'(k)) begin
                blank = upper_zero[k];
            end
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Scan index, digit select and segment bus registered on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_idx  <= '0;
            digit_sel <= DIGITS'(1);
            seg       <= 7'h3F;
        end else begin
            scan_idx  <= idx_next;
            digit_sel <= sel_next;
            seg       <= blank ? 7'h00 : seg7_decode(scan_digit);
        end
    end

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Directed bench for seg7_scan_counter: one hex and one BCD instance, both scanning every 4 clocks.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_seg7_scan_counter;

    logic        clock = 1'b0;
    logic        reset;
    logic        en_hex, clr_hex, en_bcd, clr_bcd;
    logic [15:0] cnt_hex, cnt_bcd;
    logic        co_hex, co_bcd;
    logic [6:0]  seg_hex, seg_bcd;
    logic [3:0]  sel_hex, sel_bcd;

    int checks = 0;
    int errors = 0;

`ifdef SEG7_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    always #5 clock = ~clock;

    seg7_scan_counter #(.DIGITS(4), .HEX(1), .SCAN_DIV(4)) u_hex (
        .clock(clock), .reset(reset), .enable(en_hex), .clear(clr_hex),
        .count(cnt_hex), .carry_out(co_hex), .seg(seg_hex), .digit_sel(sel_hex)
    );

    seg7_scan_counter #(.DIGITS(4), .HEX(0), .SCAN_DIV(4)) u_bcd (
        .clock(clock), .reset(reset), .enable(en_bcd), .clear(clr_bcd),
        .count(cnt_bcd), .carry_out(co_bcd), .seg(seg_bcd), .digit_sel(sel_bcd)
    );

    task automatic test_reset();
        reset = 1'b1; en_hex = 1'b0; clr_hex = 1'b0; en_bcd = 1'b0; clr_bcd = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (cnt_hex !== 16'h0) begin errors++; $display("FAIL reset_cnt_hex got %h want 0000", cnt_hex); end
        checks++; if (co_hex !== 1'b0) begin errors++; $display("FAIL reset_co_hex got %b want 0", co_hex); end
        checks++; if (sel_hex !== 4'b0001) begin errors++; $display("FAIL reset_sel_hex got %b want 0001", sel_hex); end
        checks++; if (seg_hex !== 7'h3F) begin errors++; $display("FAIL reset_seg_hex got %h want 3F", seg_hex); end
        checks++; if (cnt_bcd !== 16'h0) begin errors++; $display("FAIL reset_cnt_bcd got %h want 0000", cnt_bcd); end
        checks++; if (sel_bcd !== 4'b0001) begin errors++; $display("FAIL reset_sel_bcd got %b want 0001", sel_bcd); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (sel_hex !== 4'b0001 || seg_hex !== 7'h3F) begin
            errors++; $display("FAIL release_hold sel %b seg %h want 0001 3F", sel_hex, seg_hex);
        end
    endtask

    // BCD: 10 pulses roll digit 0 over into digit 1.
    task automatic test_bcd_count();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++; if (cnt_bcd !== 16'(i)) begin errors++; $display("FAIL bcd_step%0d got %h want %h", i, cnt_bcd, 16'(i)); end
            en_bcd = 1'b1;
        end
        @(negedge clock);
        en_bcd = 1'b0;
        checks++; if (cnt_bcd !== 16'h0010) begin errors++; $display("FAIL bcd_ten got %h want 0010", cnt_bcd); end
        checks++; if (co_bcd !== 1'b0) begin errors++; $display("FAIL bcd_ten_co got %b want 0", co_bcd); end
    endtask

    // Clear wins over a simultaneous enable.
    task automatic test_clear_priority();
        @(negedge clock); clr_bcd = 1'b1;
        @(negedge clock); clr_bcd = 1'b0;
        checks++; if (cnt_bcd !== 16'h0) begin errors++; $display("FAIL clear_plain got %h want 0000", cnt_bcd); end
        for (int i = 0; i < 9; i++) begin
            en_bcd = 1'b1;
            @(negedge clock);
        end
        checks++; if (cnt_bcd !== 16'h0009) begin errors++; $display("FAIL clear_pre got %h want 0009", cnt_bcd); end
        en_bcd = 1'b1; clr_bcd = 1'b1;
        @(negedge clock);
        en_bcd = 1'b0; clr_bcd = 1'b0;
        checks++; if (cnt_bcd !== 16'h0) begin errors++; $display("FAIL clear_prio got %h want 0000", cnt_bcd); end
        checks++; if (co_bcd !== 1'b0) begin errors++; $display("FAIL clear_prio_co got %b want 0", co_bcd); end
    endtask

    // Hex count to 0x1234, then watch the scan for five digit slots of 4 clocks each.
    task automatic test_scan();
        logic [3:0] prev;
        logic [3:0] exp_sel;
        logic [6:0] exp_seg;
        bit         found;
        for (int i = 0; i < 16'h1234; i++) begin
            @(negedge clock); en_hex = 1'b1;
        end
        @(negedge clock); en_hex = 1'b0;
        checks++; if (cnt_hex !== 16'h1234) begin errors++; $display("FAIL scan_preload got %h want 1234", cnt_hex); end
        found = 1'b0;
        for (int n = 0; n < 64 && !found; n++) begin
            prev = sel_hex;
            @(negedge clock);
            if (prev == 4'b1000 && sel_hex == 4'b0001) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL scan_sync no 1000->0001 step within 64 clocks"); end
        for (int s = 0; s < 5; s++) begin
            case (s % 4)
                0:       begin exp_sel = 4'b0001; exp_seg = 7'h66; end
                1:       begin exp_sel = 4'b0010; exp_seg = 7'h4F; end
                2:       begin exp_sel = 4'b0100; exp_seg = 7'h5B; end
                default: begin exp_sel = 4'b1000; exp_seg = 7'h06; end
            endcase
            for (int c = 0; c < 4; c++) begin
                checks++; if (sel_hex !== exp_sel || seg_hex !== exp_seg) begin
                    errors++; $display("FAIL scan_slot%0d_clk%0d sel %b seg %h want %b %h", s, c, sel_hex, seg_hex, exp_sel, exp_seg);
                end
                @(negedge clock);
            end
        end
    endtask

    // Asynchronous reset while digit 2 is on the bus with count 0x1234.
    task automatic test_mid_reset();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 32 && !found; n++) begin
            @(negedge clock);
            if (sel_hex == 4'b0100) found = 1'b1;
        end
        checks++; if (!found || cnt_hex !== 16'h1234) begin
            errors++; $display("FAIL midrst_setup sel %b cnt %h want 0100 1234", sel_hex, cnt_hex);
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (cnt_hex !== 16'h0) begin errors++; $display("FAIL midrst_cnt got %h want 0000", cnt_hex); end
        checks++; if (sel_hex !== 4'b0001) begin errors++; $display("FAIL midrst_sel got %b want 0001", sel_hex); end
        checks++; if (seg_hex !== 7'h3F) begin errors++; $display("FAIL midrst_seg got %h want 3F", seg_hex); end
        checks++; if (co_hex !== 1'b0) begin errors++; $display("FAIL midrst_co got %b want 0", co_hex); end
        @(negedge clock);
        @(negedge clock);
        checks++; if (cnt_hex !== 16'h0 || sel_hex !== 4'b0001 || seg_hex !== 7'h3F) begin
            errors++; $display("FAIL midrst_held cnt %h sel %b seg %h want 0000 0001 3F", cnt_hex, sel_hex, seg_hex);
        end
        reset = 1'b0;
    endtask

    // Leading-zero display at 0x0042 and at 0.
    task automatic test_blank();
        logic [6:0] exp_seg;
        for (int i = 0; i < 16'h42; i++) begin
            @(negedge clock); en_hex = 1'b1;
        end
        @(negedge clock); en_hex = 1'b0;
        checks++; if (cnt_hex !== 16'h0042) begin errors++; $display("FAIL blank_preload got %h want 0042", cnt_hex); end
        @(negedge clock);
        for (int n = 0; n < 16; n++) begin
            case (sel_hex)
                4'b0001: exp_seg = 7'h5B;
                4'b0010: exp_seg = 7'h66;
                4'b0100: exp_seg = BLANK ? 7'h00 : 7'h3F;
                4'b1000: exp_seg = BLANK ? 7'h00 : 7'h3F;
                default: exp_seg = 7'h7F;
            endcase
            checks++; if (seg_hex !== exp_seg) begin
                errors++; $display("FAIL blank42_%0d sel %b seg %h want %h", n, sel_hex, seg_hex, exp_seg);
            end
            @(negedge clock);
        end
        clr_hex = 1'b1;
        @(negedge clock); clr_hex = 1'b0;
        @(negedge clock);
        for (int n = 0; n < 16; n++) begin
            case (sel_hex)
                4'b0001: exp_seg = 7'h3F;
                4'b0010, 4'b0100, 4'b1000: exp_seg = BLANK ? 7'h00 : 7'h3F;
                default: exp_seg = 7'h7F;
            endcase
            checks++; if (seg_hex !== exp_seg) begin
                errors++; $display("FAIL blank0_%0d sel %b seg %h want %h", n, sel_hex, seg_hex, exp_seg);
            end
            @(negedge clock);
        end
    endtask

    // Full wrap: hex FFFF and BCD 9999 each roll to 0 with a single carry pulse.
    task automatic test_wrap();
        int co_hex_seen = 0;
        int co_bcd_seen = 0;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clock);
            if (co_hex) co_hex_seen++;
            if (co_bcd) co_bcd_seen++;
            en_hex = 1'b1;
            en_bcd = (i < 9999);
        end
        @(negedge clock);
        if (co_hex) co_hex_seen++;
        if (co_bcd) co_bcd_seen++;
        checks++; if (cnt_hex !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre_hex got %h want FFFF", cnt_hex); end
        checks++; if (cnt_bcd !== 16'h9999) begin errors++; $display("FAIL wrap_pre_bcd got %h want 9999", cnt_bcd); end
        checks++; if (co_hex_seen != 0 || co_bcd_seen != 0) begin
            errors++; $display("FAIL wrap_early_carry hex %0d bcd %0d want 0 0", co_hex_seen, co_bcd_seen);
        end
        en_hex = 1'b1; en_bcd = 1'b1;
        @(negedge clock);
        checks++; if (cnt_hex !== 16'h0 || co_hex !== 1'b1) begin
            errors++; $display("FAIL wrap_hex cnt %h co %b want 0000 1", cnt_hex, co_hex);
        end
        checks++; if (cnt_bcd !== 16'h0 || co_bcd !== 1'b1) begin
            errors++; $display("FAIL wrap_bcd cnt %h co %b want 0000 1", cnt_bcd, co_bcd);
        end
        en_hex = 1'b1; en_bcd = 1'b0;
        @(negedge clock);
        en_hex = 1'b0;
        checks++; if (cnt_hex !== 16'h0001 || co_hex !== 1'b0) begin
            errors++; $display("FAIL wrap_next_hex cnt %h co %b want 0001 0", cnt_hex, co_hex);
        end
        checks++; if (cnt_bcd !== 16'h0 || co_bcd !== 1'b0) begin
            errors++; $display("FAIL wrap_next_bcd cnt %h co %b want 0000 0", cnt_bcd, co_bcd);
        end
    endtask

    initial begin
        test_reset();
        test_bcd_count();
        test_clear_priority();
        test_scan();
        test_mid_reset();
        test_blank();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
